fpadd_arbiter: RTL

Round-robin arbiter that shares one fully pipelined FP32 adder (`fpadd_pipelined`, 3-cycle latency, one issue per cycle) among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle. A valid/ID tag travels alongside the adder pipeline so each sum is returned to the requester that issued it. The block sits between the FPU's operand sources (DMA/AXI front-end, test harness) and the adder core.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fpadd_pipelined.sv | 97 +++++++++
 rtl/rr_arbiter.sv | 38 +++
 rtl/fpadd_arbiter.sv | 78 +++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants and elaboration helpers.
package fpu_pkg;

  localparam int              FP_W          = 32;
  localparam int              FPADD_LATENCY = 3;
  localparam logic [FP_W-1:0] FP32_ZERO     = '0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fpadd_pipelined.sv
// FP32 adder, normal operands, round-to-nearest-even, zero-operand bypass; 3-cycle latency.
// Fully pipelined: accepts one operand pair every cycle, no stall input.
module fpadd_pipelined
  import fpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] out
);

  logic [31:0] a_q, b_q;
  logic        s2_sign, s2_sub, s2_byp;
  logic [7:0]  s2_exp;
  logic [26:0] s2_mbig, s2_msml;
  logic [31:0] s2_byp_val;

  logic        swap;
  logic [31:0] big;
  logic [30:0] sml;
  logic [7:0]  diff;
  logic [26:0] sml_ext, sml_sh;

  // Align: the smaller magnitude is shifted right, keeping guard/round/sticky below the LSB.
  always_comb begin
    swap    = b_q[30:0] > a_q[30:0];
    big     = swap ? b_q : a_q;
    sml     = swap ? a_q[30:0] : b_q[30:0];
    diff    = big[30:23] - sml[30:23];
    sml_ext = {1'b1, sml[22:0], 3'b000};
    if (diff > 8'd26) sml_sh = 27'd1;
    else sml_sh = (sml_ext >> diff) | {26'd0, |(sml_ext & ~({27{1'b1}} << diff))};
  end

  logic [27:0]       sum;
  logic [26:0]       norm;
  logic [4:0]        lz;
  logic              found, rnd_up;
  logic signed [9:0] exp_n;
  logic [23:0]       frac_r;
  logic [31:0]       res;

  always_comb begin
    sum   = s2_sub ? {1'b0, s2_mbig} - {1'b0, s2_msml} : {1'b0, s2_mbig} + {1'b0, s2_msml};
    lz    = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--)
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, s2_exp}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, s2_exp}) - $signed({5'd0, lz});
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    frac_r = {1'b0, norm[25:3]} + 24'(rnd_up);
    if (frac_r[23]) exp_n = exp_n + 10'sd1;
    // A cleared hidden bit only happens on exact cancellation, which yields +0.
    if (s2_byp)             res = s2_byp_val;
    else if (!norm[26])     res = FP32_ZERO;
    else if (exp_n <= 0)    res = {s2_sign, 31'd0};
    else if (exp_n >= 255)  res = {s2_sign, 8'hFF, 23'd0};
    else                    res = {s2_sign, exp_n[7:0], frac_r[22:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      s2_sign    <= 1'b0;
      s2_sub     <= 1'b0;
      s2_byp     <= 1'b0;
      s2_exp     <= '0;
      s2_mbig    <= '0;
      s2_msml    <= '0;
      s2_byp_val <= '0;
      out        <= '0;
    end else begin
      a_q        <= a;
      b_q        <= b;
      s2_sign    <= big[31];
      s2_sub     <= a_q[31] ^ b_q[31];
      s2_exp     <= big[30:23];
      s2_mbig    <= {1'b1, big[22:0], 3'b000};
      s2_msml    <= sml_sh;
      s2_byp     <= (a_q[30:23] == 8'd0) | (b_q[30:23] == 8'd0);
      s2_byp_val <= (a_q[30:23] == 8'd0) ? b_q : a_q;
      out        <= res;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning upward from ptr with wrap.
// Pointer moves past the winner on every grant, holds when idle.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win,
  output logic            any
);

  logic [IDW-1:0] ptr_q;
  int             idx;

  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_q) + off) % NREQ;
      if (!any && valid[idx]) begin
        any        = 1'b1;
        win        = IDW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    ptr_q <= '0;
    else if (any) ptr_q <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one pipelined FP32 adder among NREQ requesters; result returns ADD_LATENCY cycles after grant.
// Requests stall until granted; responses cannot be stalled and must be taken when shown.
module fpadd_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int ADD_LATENCY = FPADD_LATENCY,
  parameter int IDW         = clog2(NREQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ*FP_W-1:0]              req_a,
  input  logic [NREQ*FP_W-1:0]              req_b,
  output logic [NREQ-1:0]                   req_ready,
  output logic [NREQ-1:0]                   resp_valid,
  output logic [FP_W-1:0]                   resp_data,
  output logic [IDW-1:0]                    resp_id,
  output logic [clog2(ADD_LATENCY+1)-1:0]   inflight,
  output logic [31:0]                       issued_cnt
);

  localparam int INFW = clog2(ADD_LATENCY + 1);
  localparam logic [NREQ-1:0] ONE = 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]  win;
  logic            xfer;
  logic [FP_W-1:0] add_a, add_b;
  tag_t            tag_q [ADD_LATENCY];
  logic [31:0]     cnt_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (req_valid),
    .grant (req_ready),
    .win   (win),
    .any   (xfer)
  );

  // Idle cycles feed 0+0 so the adder output reads zero whenever no tag is valid.
  assign add_a = xfer ? req_a[int'(win)*FP_W +: FP_W] : FP32_ZERO;
  assign add_b = xfer ? req_b[int'(win)*FP_W +: FP_W] : FP32_ZERO;

  fpadd_pipelined u_add (
    .clk   (clk),
    .reset (reset),
    .a     (add_a),
    .b     (add_b),
    .out   (resp_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ADD_LATENCY; i++) tag_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      tag_q[0] <= tag_t'{vld: xfer, id: win};
      for (int i = 1; i < ADD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      cnt_q <= cnt_q + 32'(xfer);
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ADD_LATENCY; i++) inflight = inflight + INFW'(tag_q[i].vld);
  end

  assign resp_valid = tag_q[ADD_LATENCY-1].vld ? (ONE << tag_q[ADD_LATENCY-1].id) : '0;
  assign resp_id    = tag_q[ADD_LATENCY-1].id;
  assign issued_cnt = cnt_q;

endmodule
